uart_apb_regs: RTL and testbench

Parametrised APB register block for the UART, successor to the single-byte buffer register file. It sits between the APB bus and the UART TX/RX engines and provides TX and RX FIFOs of configurable depth, a baud divisor register, a live status register, sticky write-1-to-clear error flags and one maskable interrupt line. All state is in one clock domain.

---
 rtl/uart_regs_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_apb_regs.sv | 163 ++++++++++++++++
 tb/tb_uart_apb_regs.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regs_pkg.sv
// Shared constants for the UART APB register block: register offsets
// and bit positions inside CTRL and ERR.
package uart_regs_pkg;

    // Register byte offsets (only pAddr[7:0] is decoded)
    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h01;
    localparam logic [7:0] ADDR_DIV    = 8'h02;
    localparam logic [7:0] ADDR_STATUS = 8'h03;
    localparam logic [7:0] ADDR_ERR    = 8'h04;

    // CTRL bit positions
    localparam int CTRL_TXEN  = 0;
    localparam int CTRL_RXEN  = 1;
    localparam int CTRL_TXEIE = 2;
    localparam int CTRL_RXAIE = 3;
    localparam int CTRL_ERRIE = 4;
    localparam int CTRL_LOOP  = 5;

    // ERR bit positions
    localparam int ERR_RXOVR = 0;
    localparam int ERR_FE    = 1;
    localparam int ERR_TXOVF = 2;
    localparam int ERR_W     = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. A pop on an empty FIFO is
// ignored; a push on a full FIFO is accepted only if a pop happens in the
// same cycle. dout reads 0 while the FIFO is empty.
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level     = r_wptr - r_rptr;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Pointer update; the extra MSB tells full apart from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_apb_regs.sv
// APB register block for the UART: TX/RX FIFOs, baud divisor, live status,
// sticky W1C error flags and one registered interrupt.
// Optional feature macro: UART_REGS_LOOPBACK_EN (CTRL[5] LOOP, TX->RX path).
//
// TX handshake: TxValid is high while the TX FIFO holds data, TxEn=1 and
// loopback is off. A TxReady pulse in a cycle where TxValid is high pops
// the head; TxReady while TxValid is low has no effect. TxData is the head.
module uart_apb_regs
    import uart_regs_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int DIV_W    = 12
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSel,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [31:0]       pAddr,
    input  logic [31:0]       pWdata,
    output logic [31:0]       pReadData,
    output logic [DATA_W-1:0] TxData,
    output logic              TxValid,
    input  logic              TxReady,
    input  logic [DATA_W-1:0] RxData,
    input  logic              RxDone,
    input  logic              RxFrameErr,
    output logic [DIV_W-1:0]  Divisor,
    output logic              TxEn,
    output logic              RxEn,
    output logic              Irq
);
`ifdef UART_REGS_LOOPBACK_EN
    localparam int CTRL_W = 6;
`else
    localparam int CTRL_W = 5;
`endif
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;

    logic [CTRL_W-1:0] r_ctrl;
    logic [DIV_W-1:0]  r_div;
    logic [ERR_W-1:0]  r_err;
    logic              r_irq;

    logic              w_wr, w_rd;
    logic [7:0]        w_addr;
    logic              w_loop_act, w_loop_move;
    logic              w_tx_wr, w_tx_pop, w_tx_valid;
    logic              w_tx_full, w_tx_empty;
    logic [DATA_W-1:0] w_tx_dout;
    logic [TX_LW-1:0]  w_tx_level;
    logic              w_rx_ext, w_rx_push, w_rx_pop, w_rx_pop_eff;
    logic              w_rx_full, w_rx_empty;
    logic [DATA_W-1:0] w_rx_din, w_rx_dout;
    logic [RX_LW-1:0]  w_rx_level;
    logic [ERR_W-1:0]  w_err_set, w_err_clr;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_wr   = pSel & pEnable & pWrite;
    assign w_rd   = pSel & pEnable & ~pWrite;
    assign w_addr = pAddr[7:0];

`ifdef UART_REGS_LOOPBACK_EN
    assign w_loop_act = r_ctrl[CTRL_LOOP] & r_ctrl[CTRL_TXEN];
`else
    assign w_loop_act = 1'b0;
`endif

    assign w_rx_pop     = w_rd & (w_addr == ADDR_DATA);
    assign w_rx_pop_eff = w_rx_pop & ~w_rx_empty;
    assign w_loop_move  = w_loop_act & ~w_tx_empty & (~w_rx_full | w_rx_pop_eff);

    assign w_tx_wr    = w_wr & (w_addr == ADDR_DATA);
    assign w_tx_valid = ~w_tx_empty & r_ctrl[CTRL_TXEN] & ~w_loop_act;
    assign w_tx_pop   = (TxReady & w_tx_valid) | w_loop_move;

    assign w_rx_ext  = RxDone & r_ctrl[CTRL_RXEN] & ~w_loop_act;
    assign w_rx_push = w_rx_ext | w_loop_move;
    assign w_rx_din  = w_loop_move ? w_tx_dout : RxData;

    assign w_err_set[ERR_RXOVR] = w_rx_ext & w_rx_full & ~w_rx_pop_eff;
    assign w_err_set[ERR_FE]    = w_rx_ext & RxFrameErr;
    assign w_err_set[ERR_TXOVF] = w_tx_wr & w_tx_full & ~w_tx_pop;
    assign w_err_clr = (w_wr && (w_addr == ADDR_ERR)) ? pWdata[ERR_W-1:0] : '0;

    uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (pClk),
        .rst_n (pReset),
        .push  (w_tx_wr),
        .pop   (w_tx_pop),
        .din   (pWdata[DATA_W-1:0]),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (w_tx_level)
    );

    uart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (pClk),
        .rst_n (pReset),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (w_rx_din),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (w_rx_level)
    );

    // CTRL/DIV writes, sticky errors (set beats clear) and registered interrupt
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_ctrl <= '0;
            r_div  <= '0;
            r_err  <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (w_addr == ADDR_CTRL)) r_ctrl <= pWdata[CTRL_W-1:0];
            if (w_wr && (w_addr == ADDR_DIV))  r_div  <= pWdata[DIV_W-1:0];
            r_err <= (r_err & ~w_err_clr) | w_err_set;
            r_irq <= (r_ctrl[CTRL_TXEIE] & w_tx_empty) |
                     (r_ctrl[CTRL_RXAIE] & ~w_rx_empty) |
                     (r_ctrl[CTRL_ERRIE] & (|r_err));
        end
    end

    assign w_status = {8'h00,
                       {(8-RX_LW){1'b0}}, w_rx_level,
                       {(8-TX_LW){1'b0}}, w_tx_level,
                       4'h0, w_rx_full, w_tx_full, w_tx_empty, ~w_rx_empty};

    // Read mux; zero outside a read access phase and for unmapped offsets
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_addr)
                ADDR_DATA:   w_rdata = {{(32-DATA_W){1'b0}}, w_rx_dout};
                ADDR_CTRL:   w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
                ADDR_DIV:    w_rdata = {{(32-DIV_W){1'b0}}, r_div};
                ADDR_STATUS: w_rdata = w_status;
                ADDR_ERR:    w_rdata = {{(32-ERR_W){1'b0}}, r_err};
                default:     w_rdata = '0;
            endcase
        end
    end

    assign pReadData = w_rdata;
    assign TxData    = w_tx_dout;
    assign TxValid   = w_tx_valid;
    assign Divisor   = r_div;
    assign TxEn      = r_ctrl[CTRL_TXEN];
    assign RxEn      = r_ctrl[CTRL_RXEN];
    assign Irq       = r_irq;

    // Upper address bits are not decoded
    assign w_unused = &{1'b0, pAddr[31:8], pWdata};

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: directed sequences plus random traffic checked
// against a queue-based model of the register block.
module tb_uart_apb_regs;
  localparam int DATA_W   = 8;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int DIV_W    = 12;
`ifdef UART_REGS_LOOPBACK_EN
  localparam logic [31:0] CTRL_MASK = 32'h3F;
`else
  localparam logic [31:0] CTRL_MASK = 32'h1F;
`endif

  logic              pClk;
  logic              pReset;
  logic              pSel, pEnable, pWrite;
  logic [31:0]       pAddr, pWdata, pReadData;
  logic [DATA_W-1:0] TxData;
  logic              TxValid, TxReady;
  logic [DATA_W-1:0] RxData;
  logic              RxDone, RxFrameErr;
  logic [DIV_W-1:0]  Divisor;
  logic              TxEn, RxEn, Irq;

  uart_apb_regs #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_W(DIV_W)) dut (
    .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .RxData(RxData), .RxDone(RxDone), .RxFrameErr(RxFrameErr),
    .Divisor(Divisor), .TxEn(TxEn), .RxEn(RxEn), .Irq(Irq)
  );

  // ---------------- clock / reset ----------------
  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_tx[$];
  logic [DATA_W-1:0] m_rx[$];
  logic [31:0]       m_ctrl;
  logic [DIV_W-1:0]  m_div;
  logic [2:0]        m_err;
  logic              m_irq;

  // scoreboard queues
  logic [31:0]       rd_exp_q[$];
  logic [DATA_W-1:0] tx_exp_q[$];
  logic [DIV_W+3:0]  out_exp_q[$];

  int n_cmp;
  int n_fail;
  bit mon_en;

  function automatic bit m_loop();
    return m_ctrl[5] && m_ctrl[0];
  endfunction

  function automatic bit m_txvalid();
    return (m_tx.size() != 0) && m_ctrl[0] && !m_loop();
  endfunction

  task automatic model_reset();
    m_tx.delete(); m_rx.delete();
    m_ctrl = '0; m_div = '0; m_err = '0; m_irq = 1'b0;
    rd_exp_q.delete(); tx_exp_q.delete(); out_exp_q.delete();
  endtask

  // One clock cycle of the block, from the inputs currently driven
  task automatic model_step();
    bit rd, wr, rx_pop, tx_pop, move, ext, loop, irq_n;
    logic [7:0] a;
    int txn, rxn;
    logic [31:0] rv;
    logic [2:0] set, clr;
    logic [DATA_W-1:0] head;
    a    = pAddr[7:0];
    rd   = pSel && pEnable && !pWrite;
    wr   = pSel && pEnable && pWrite;
    txn  = m_tx.size();
    rxn  = m_rx.size();
    loop = m_loop();
    out_exp_q.push_back({m_irq, m_txvalid(), m_ctrl[0], m_ctrl[1], m_div});
    if (rd) begin
      case (a)
        8'h00:   rv = (rxn != 0) ? 32'(m_rx[0]) : 32'h0;
        8'h01:   rv = m_ctrl;
        8'h02:   rv = 32'(m_div);
        8'h03:   rv = {8'h00, 8'(rxn), 8'(txn), 4'h0, rxn == RX_DEPTH, txn == TX_DEPTH, txn == 0, rxn != 0};
        8'h04:   rv = 32'(m_err);
        default: rv = 32'h0;
      endcase
      rd_exp_q.push_back(rv);
    end
    tx_pop = TxReady && m_txvalid();
    if (tx_pop) tx_exp_q.push_back(m_tx[0]);
    irq_n  = (m_ctrl[2] && txn == 0) || (m_ctrl[3] && rxn != 0) || (m_ctrl[4] && m_err != 0);
    rx_pop = rd && a == 8'h00 && rxn != 0;
    move   = loop && txn != 0 && (rxn < RX_DEPTH || rx_pop);
    ext    = RxDone && m_ctrl[1] && !loop;
    set = 3'b0;
    if (wr && a == 8'h00 && txn == TX_DEPTH && !(tx_pop || move)) set[2] = 1'b1;
    if (ext && rxn == RX_DEPTH && !rx_pop) set[0] = 1'b1;
    if (ext && RxFrameErr) set[1] = 1'b1;
    clr  = (wr && a == 8'h04) ? pWdata[2:0] : 3'b0;
    head = (txn != 0) ? m_tx[0] : '0;
    if (tx_pop || move) void'(m_tx.pop_front());
    if (wr && a == 8'h00 && (txn < TX_DEPTH || tx_pop || move)) m_tx.push_back(pWdata[DATA_W-1:0]);
    if (rx_pop) void'(m_rx.pop_front());
    if (ext && (rxn < RX_DEPTH || rx_pop)) m_rx.push_back(RxData);
    if (move) m_rx.push_back(head);
    m_err = (m_err & ~clr) | set;
    if (wr && a == 8'h01) m_ctrl = pWdata & CTRL_MASK;
    if (wr && a == 8'h02) m_div = pWdata[DIV_W-1:0];
    m_irq = irq_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge pClk);
    #1;
    TxReady = 1'b0; RxDone = 1'b0; RxFrameErr = 1'b0;
  endtask

  task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                     input bit rxd = 1'b0, input logic [DATA_W-1:0] rdat = '0, input bit fe = 1'b0);
    pSel = 1'b1; pEnable = 1'b0; pWrite = w;
    pAddr = {24'($urandom), a}; pWdata = d;
    tick();
    pEnable = 1'b1;
    RxDone = rxd; RxData = rdat; RxFrameErr = fe;
    tick();
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask

  task automatic pulse_rx(input logic [DATA_W-1:0] d, input bit fe);
    RxDone = 1'b1; RxData = d; RxFrameErr = fe;
    tick();
  endtask

  task automatic pulse_tx();
    TxReady = 1'b1;
    tick();
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0]       e_rd;
  logic [DATA_W-1:0] e_tx;
  logic [DIV_W+3:0]  e_out;

  always @(negedge pClk) begin
    if (mon_en) begin
      if (pSel && pEnable && !pWrite) begin
        n_cmp++;
        if (rd_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: got %0h with no read expected", pReadData);
        end else begin
          e_rd = rd_exp_q.pop_front();
          if (pReadData !== e_rd) begin
            n_fail++;
            $display("FAIL rd_data addr %0h: got %0h expected %0h", pAddr[7:0], pReadData, e_rd);
          end
        end
      end
      if (TxReady && TxValid) begin
        n_cmp++;
        if (tx_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_data: pop of %0h with none expected", TxData);
        end else begin
          e_tx = tx_exp_q.pop_front();
          if (TxData !== e_tx) begin
            n_fail++;
            $display("FAIL tx_data: got %0h expected %0h", TxData, e_tx);
          end
        end
      end
      if (out_exp_q.size() != 0) begin
        e_out = out_exp_q.pop_front();
        n_cmp++;
        if ({Irq, TxValid, TxEn, RxEn, Divisor} !== e_out) begin
          n_fail++;
          $display("FAIL outputs {Irq,TxValid,TxEn,RxEn,Divisor}: got %0h expected %0h",
                   {Irq, TxValid, TxEn, RxEn, Divisor}, e_out);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int op;
  bit rxd, fe;
  logic [DATA_W-1:0] rdat;
  logic [31:0] cv;

  initial begin
    n_cmp = 0; n_fail = 0; mon_en = 1'b0;
    pReset = 1'b0; pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    pAddr = '0; pWdata = '0; TxReady = 1'b0; RxData = '0; RxDone = 1'b0; RxFrameErr = 1'b0;
    model_reset();
    repeat (3) @(posedge pClk);
    #1;
    check("reset_outputs", {pReadData, TxData, TxValid, Divisor, TxEn, RxEn, Irq}, '0);
    pReset = 1'b1;
    mon_en = 1'b1;

    // reset register contents
    apb(0, 8'h03, 0);
    apb(0, 8'h04, 0);
    apb(0, 8'h01, 0);

    // TX fill past full, then drain through TxReady
    apb(1, 8'h01, 32'h1);
    for (int i = 1; i <= 5; i++) apb(1, 8'h00, 32'h11 * i);
    apb(0, 8'h03, 0);
    apb(0, 8'h04, 0);
    apb(1, 8'h04, 32'h4);
    repeat (5) pulse_tx();

    // RX overflow then drain, including an extra read of an empty FIFO
    apb(1, 8'h01, 32'h3);
    for (int i = 0; i < 5; i++) pulse_rx(8'hA0 + 8'(i), 1'b0);
    apb(0, 8'h04, 0);
    repeat (5) apb(0, 8'h00, 0);
    apb(1, 8'h04, 32'h7);

    // RX full with simultaneous pop and push
    for (int i = 1; i <= 4; i++) pulse_rx(8'hB0 + 8'(i), 1'b0);
    apb(0, 8'h00, 0, 1'b1, 8'hB5, 1'b0);
    apb(0, 8'h04, 0);
    apb(0, 8'h03, 0);
    repeat (4) apb(0, 8'h00, 0);

    // RX-available interrupt, frame error, W1C racing a new error
    apb(1, 8'h01, 32'h0B);
    pulse_rx(8'h3C, 1'b0);
    repeat (3) tick();
    apb(0, 8'h00, 0);
    pulse_rx(8'h44, 1'b1);
    apb(0, 8'h04, 0);
    apb(1, 8'h04, 32'h2);
    apb(0, 8'h04, 0);
    apb(1, 8'h04, 32'h2, 1'b1, 8'h45, 1'b1);
    apb(0, 8'h04, 0);
    apb(1, 8'h01, 32'h13);
    repeat (2) tick();
    repeat (2) apb(0, 8'h00, 0);
    apb(1, 8'h04, 32'h7);

    // CTRL masking, DIV, unmapped offsets, RX ignored while disabled
    apb(1, 8'h01, 32'hFFFF_FFFF);
    apb(0, 8'h01, 0);
    apb(1, 8'h01, 32'h1);
    pulse_rx(8'h77, 1'b1);
    apb(0, 8'h03, 0);
    apb(1, 8'h02, 32'hFFFF_FABC);
    apb(0, 8'h02, 0);
    apb(1, 8'h07, 32'hFFFF_FFFF);
    apb(0, 8'h07, 0);
    apb(0, 8'h05, 0);

`ifdef UART_REGS_LOOPBACK_EN
    // loopback: TX head moves into RX, TxValid stays low
    apb(1, 8'h01, 32'h21);
    apb(1, 8'h00, 32'h5A);
    repeat (2) tick();
    apb(0, 8'h03, 0);
    apb(0, 8'h00, 0);
    apb(1, 8'h01, 32'h3);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      op   = $urandom_range(0, 9);
      rxd  = ($urandom_range(0, 3) == 0);
      fe   = ($urandom_range(0, 7) == 0);
      rdat = DATA_W'($urandom);
      case (op)
        0, 1: apb(1, 8'h00, $urandom, rxd, rdat, fe);
        2, 3: apb(0, 8'h00, 0, rxd, rdat, fe);
        4:    apb(0, 8'h03, 0, rxd, rdat, fe);
        5: begin
          if ($urandom_range(0, 1) == 1) apb(0, 8'h04, 0, rxd, rdat, fe);
          else apb(1, 8'h04, $urandom, rxd, rdat, fe);
        end
        6: begin
          cv = $urandom;
          if ($urandom_range(0, 3) != 0) cv = cv | 32'h3;
          apb(1, 8'h01, cv, rxd, rdat, fe);
        end
        7: begin
          case ($urandom_range(0, 3))
            0: apb(0, 8'h01, 0, rxd, rdat, fe);
            1: apb(0, 8'h02, 0, rxd, rdat, fe);
            2: apb(1, 8'h02, $urandom, rxd, rdat, fe);
            default: apb($urandom_range(0, 1) == 1, 8'($urandom_range(5, 255)), $urandom, rxd, rdat, fe);
          endcase
        end
        8: pulse_rx(rdat, fe);
        default: begin
          if (m_tx.size() == 0 || m_txvalid()) pulse_tx();
          else tick();
        end
      endcase
    end
    tick();

    check("rd_exp_q_left", 64'(rd_exp_q.size()), 64'd0);
    check("tx_exp_q_left", 64'(tx_exp_q.size()), 64'd0);

    // asynchronous reset in the middle of an access phase
    apb(1, 8'h01, 32'h17);
    apb(1, 8'h02, 32'h123);
    apb(1, 8'h00, 32'h99);
    tick();
    mon_en = 1'b0;
    pSel = 1'b1; pEnable = 1'b1; pWrite = 1'b1; pAddr = 32'h0; pWdata = 32'h66;
    #2;
    pReset = 1'b0;
    #1;
    check("async_reset_outputs", {TxData, TxValid, Divisor, TxEn, RxEn, Irq}, '0);
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    model_reset();
    @(posedge pClk);
    #1;
    pReset = 1'b1;
    mon_en = 1'b1;
    apb(0, 8'h03, 0);
    apb(0, 8'h01, 0);
    tick();

    check("rd_exp_q_end", 64'(rd_exp_q.size()), 64'd0);
    check("tx_exp_q_end", 64'(tx_exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
